// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, round helper functions and the controller state type
// for the multi-nonce second-pass hasher.
package sha256_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, FINAL, WRITE} state_e;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_lane.sv
// One SHA-256 round engine: eight working registers plus a 16-word message window,
// loaded with a padded 256-bit message and stepped once per round.
module sha256_lane
    import sha256_pkg::*;
(
    input  logic             clk,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [5:0]       round_i,
    input  logic [7:0][31:0] msg_i,
    output logic [7:0][31:0] digest_o
);

    logic [31:0] work_q [8];
    logic [31:0] work_d [8];
    logic [31:0] w_q    [16];
    logic [31:0] w_d    [16];
    logic [31:0] wt;
    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
        work_d = work_q;
        w_d    = w_q;
        // Rounds 0..15 rotate the loaded words through; later rounds extend the schedule in place.
        wt = (round_i[5:4] == 2'b00) ? w_q[0]
           : small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
        t1 = work_q[7] + big_sigma1(work_q[4]) + ch(work_q[4], work_q[5], work_q[6]) + K[round_i] + wt;
        t2 = big_sigma0(work_q[0]) + maj(work_q[0], work_q[1], work_q[2]);
        if (load_i) begin
            for (int i = 0; i < 8; i++) begin
                work_d[i] = IV[i];
                w_d[i]    = msg_i[i];
            end
            w_d[8] = 32'h8000_0000;
            for (int i = 9; i < 15; i++) w_d[i] = '0;
            w_d[15] = 32'h0000_0100;
        end else if (step_i) begin
            for (int i = 7; i > 0; i--) work_d[i] = work_q[i-1];
            work_d[4] = work_q[3] + t1;
            work_d[0] = t1 + t2;
            for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
            w_d[15] = wt;
        end
    end

    // NOTE: pure datapath storage is left without reset; load_i always initialises it before use.
    always_ff @(posedge clk) begin
        work_q <= work_d;
        w_q    <= w_d;
    end

    always_comb begin
        for (int j = 0; j < 8; j++) digest_o[j] = IV[j] + work_q[j];
    end

endmodule

// File: rtl/sha256_nonce_array.sv
// Batched SHA-256 second-pass hasher: NUM_LANES engines hash NUM_NONCES digests and
// stream results to word memory. Optional min-h0 tracking via SHA256_NONCE_MIN_TRACK_EN.
module sha256_nonce_array
    import sha256_pkg::*;
#(
    parameter int NUM_NONCES = 16,
    parameter int NUM_LANES  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [15:0]                 output_addr,
    input  logic [NUM_NONCES*256-1:0]   hin,
    output logic                        done,
    output logic                        mem_clk,
    output logic                        mem_we,
    output logic [15:0]                 mem_addr,
    output logic [31:0]                 mem_write_data
`ifdef SHA256_NONCE_MIN_TRACK_EN
    ,
    output logic [31:0]                 min_h0,
    output logic [(NUM_NONCES > 1 ? $clog2(NUM_NONCES) : 1)-1:0] min_nonce
`endif
);

    localparam int NUM_BATCHES = NUM_NONCES / NUM_LANES;
    localparam int BATCH_W     = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
    localparam int WI_W        = $clog2(8 * NUM_LANES + 1);
    localparam int NONCE_W     = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;

    state_e                           state_q;
    logic [BATCH_W-1:0]               batch_q;
    logic [5:0]                       round_q;
    logic [WI_W-1:0]                  wi_q;
    logic                             done_q;
    logic                             mem_we_q;
    logic [15:0]                      mem_addr_q;
    logic [31:0]                      mem_data_q;
    logic [NUM_LANES-1:0][7:0][31:0]  lane_digest;
    logic [31:0]                      wr_word;
    logic                             lane_load;
    logic                             lane_step;

    assign lane_load = (state_q == LOAD);
    assign lane_step = (state_q == COMPUTE);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [7:0][31:0] msg;

        always_comb begin
            msg = '0;
            for (int b = 0; b < NUM_BATCHES; b++) begin
                if (batch_q == BATCH_W'(b)) begin
                    for (int j = 0; j < 8; j++) msg[j] = hin[(b*NUM_LANES + l)*256 + (7-j)*32 +: 32];
                end
            end
        end

        sha256_lane u_lane (
            .clk      (clk),
            .load_i   (lane_load),
            .step_i   (lane_step),
            .round_i  (round_q),
            .msg_i    (msg),
            .digest_o (lane_digest[l])
        );
    end

    // Write index wi selects lane wi/8, word wi%8.
    always_comb begin
        wr_word = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int j = 0; j < 8; j++) begin
                if (wi_q == WI_W'(l*8 + j)) wr_word = lane_digest[l][j];
            end
        end
    end

`ifdef SHA256_NONCE_MIN_TRACK_EN
    logic [31:0]        min_h0_q;
    logic [NONCE_W-1:0] min_nonce_q;
    logic [31:0]        cand_h0;
    logic [NONCE_W-1:0] cand_nonce;

    // Ascending lane scan with strict compare keeps the lowest nonce on ties.
    always_comb begin
        cand_h0    = min_h0_q;
        cand_nonce = min_nonce_q;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_digest[l][0] < cand_h0) begin
                cand_h0    = lane_digest[l][0];
                cand_nonce = NONCE_W'(int'(batch_q) * NUM_LANES + l);
            end
        end
    end

    assign min_h0    = min_h0_q;
    assign min_nonce = min_nonce_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            batch_q    <= '0;
            round_q    <= '0;
            wi_q       <= '0;
            done_q     <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
`ifdef SHA256_NONCE_MIN_TRACK_EN
            min_h0_q    <= '0;
            min_nonce_q <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    done_q <= !start;
                    if (start) begin
                        state_q <= LOAD;
                        batch_q <= '0;
`ifdef SHA256_NONCE_MIN_TRACK_EN
                        min_h0_q    <= 32'hFFFF_FFFF;
                        min_nonce_q <= '0;
`endif
                    end
                end
                LOAD: begin
                    round_q <= '0;
                    state_q <= COMPUTE;
                end
                COMPUTE: begin
                    round_q <= round_q + 6'd1;
                    if (round_q == 6'd63) state_q <= FINAL;
                end
                FINAL: begin
                    wi_q    <= '0;
                    state_q <= WRITE;
`ifdef SHA256_NONCE_MIN_TRACK_EN
                    min_h0_q    <= cand_h0;
                    min_nonce_q <= cand_nonce;
`endif
                end
                WRITE: begin
                    // wi == 8*NUM_LANES is a one-cycle drain after the final batch.
                    if (wi_q == WI_W'(8 * NUM_LANES)) begin
                        state_q <= IDLE;
                    end else begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= output_addr + 16'(batch_q) * 16'(8 * NUM_LANES) + 16'(wi_q);
                        mem_data_q <= wr_word;
                        if (wi_q == WI_W'(8 * NUM_LANES - 1) && batch_q != BATCH_W'(NUM_BATCHES - 1)) begin
                            batch_q <= batch_q + 1'b1;
                            state_q <= LOAD;
                        end else begin
                            wi_q <= wi_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done           = done_q;
    assign mem_clk        = clk;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_data_q;

endmodule

// File: tb/tb_sha256_nonce_array.sv
// Directed bench for sha256_nonce_array: a 1x1 instance for known-answer, wrap and
// abort tests, and a 16-nonce/4-lane instance checked against a reference SHA-256.
module tb_sha256_nonce_array;
    import sha256_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic         a_start, a_done, a_mclk, a_we;
    logic [15:0]  a_addr, a_maddr;
    logic [255:0] a_hin;
    logic [31:0]  a_mdata;

    logic          b_start, b_done, b_mclk, b_we;
    logic [15:0]   b_addr, b_maddr;
    logic [4095:0] b_hin;
    logic [31:0]   b_mdata;

`ifdef SHA256_NONCE_MIN_TRACK_EN
    logic [31:0] a_min_h0, b_min_h0;
    logic [0:0]  a_min_nonce;
    logic [3:0]  b_min_nonce;
`endif

    sha256_nonce_array #(.NUM_NONCES(1), .NUM_LANES(1)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .output_addr(a_addr), .hin(a_hin),
        .done(a_done), .mem_clk(a_mclk), .mem_we(a_we), .mem_addr(a_maddr), .mem_write_data(a_mdata)
`ifdef SHA256_NONCE_MIN_TRACK_EN
        , .min_h0(a_min_h0), .min_nonce(a_min_nonce)
`endif
    );

    sha256_nonce_array #(.NUM_NONCES(16), .NUM_LANES(4)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .output_addr(b_addr), .hin(b_hin),
        .done(b_done), .mem_clk(b_mclk), .mem_we(b_we), .mem_addr(b_maddr), .mem_write_data(b_mdata)
`ifdef SHA256_NONCE_MIN_TRACK_EN
        , .min_h0(b_min_h0), .min_nonce(b_min_nonce)
`endif
    );

    // Captured memory writes, in issue order.
    logic [15:0] a_wa [$];
    logic [31:0] a_wd [$];
    logic [15:0] b_wa [$];
    logic [31:0] b_wd [$];

    always @(negedge clk) begin
        if (a_we === 1'b1) begin a_wa.push_back(a_maddr); a_wd.push_back(a_mdata); end
        if (b_we === 1'b1) begin b_wa.push_back(b_maddr); b_wd.push_back(b_mdata); end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook single-block SHA-256 of a 256-bit message; h0 in the top word.
    function automatic logic [255:0] sha_ref(input logic [255:0] m);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] s0, s1, t1, t2;
        for (int t = 0; t < 8; t++) w[t] = m[255 - 32*t -: 32];
        w[8] = 32'h8000_0000;
        for (int t = 9; t < 15; t++) w[t] = 32'h0;
        w[15] = 32'd256;
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = IV[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) sha_ref[255 - 32*i -: 32] = IV[i] + v[i];
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [31:0]  zero_dig [8];
        logic [255:0] msg, dig, best, cand;
        logic [255:0] b_exp [16];
        int           cyc;

        zero_dig = '{32'h66687aad, 32'hf862bd77, 32'h6c8fc18b, 32'h8e9f8e20,
                     32'h08971485, 32'h6ee233b3, 32'h902a591d, 32'h0d5f2925};
        reset = 1'b1; a_start = 1'b0; b_start = 1'b0;
        a_addr = '0; b_addr = '0; a_hin = '0; b_hin = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_a_done", 32'(a_done), 32'd1);
        check("rst_a_we", 32'(a_we), 32'd0);
        check("rst_a_addr", 32'(a_maddr), 32'd0);
        check("rst_a_data", a_mdata, 32'd0);
        check("rst_b_done", 32'(b_done), 32'd1);
`ifdef SHA256_NONCE_MIN_TRACK_EN
        check("rst_b_min_h0", b_min_h0, 32'd0);
        check("rst_b_min_nonce", 32'(b_min_nonce), 32'd0);
`endif

        // Known answer: all-zero input digest.
        a_hin = '0; a_addr = 16'h0100; a_wa.delete(); a_wd.delete();
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        cyc = 0;
        while (a_done !== 1'b1 && cyc < 1000) begin @(negedge clk); cyc++; end
        check("kat_latency", 32'(cyc), 32'd76);
        check("kat_nwrites", 32'(a_wa.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("kat_addr%0d", i), 32'(a_wa[i]), 32'h0100 + 32'(i));
            check($sformatf("kat_data%0d", i), a_wd[i], zero_dig[i]);
        end

        // Address wrap from FFFC.
        msg = rand256(); dig = sha_ref(msg);
        a_hin = msg; a_addr = 16'hFFFC; a_wa.delete(); a_wd.delete();
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        cyc = 0;
        while (a_done !== 1'b1 && cyc < 1000) begin @(negedge clk); cyc++; end
        check("wrap_nwrites", 32'(a_wa.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wrap_addr%0d", i), 32'(a_wa[i]), 32'(16'(16'hFFFC + i)));
            check($sformatf("wrap_data%0d", i), a_wd[i], dig[255 - 32*i -: 32]);
        end

        // Second start during COMPUTE is ignored; reset during WRITE aborts.
        msg = rand256(); dig = sha_ref(msg);
        a_hin = msg; a_addr = 16'h0300; a_wa.delete(); a_wd.delete();
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        repeat (10) @(negedge clk);
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        cyc = 11;
        while (a_we !== 1'b1 && cyc < 1000) begin @(negedge clk); cyc++; end
        check("restart_first_write", 32'(cyc), 32'd67);
        repeat (2) @(negedge clk);
        reset = 1'b1; @(negedge clk);
        check("abort_we", 32'(a_we), 32'd0);
        check("abort_done", 32'(a_done), 32'd1);
        reset = 1'b0;
        check("abort_partial_n", 32'(a_wa.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort_addr%0d", i), 32'(a_wa[i]), 32'h0300 + 32'(i));
            check($sformatf("abort_data%0d", i), a_wd[i], dig[255 - 32*i -: 32]);
        end
        a_wa.delete(); a_wd.delete();
        repeat (100) @(negedge clk);
        check("abort_no_writes", 32'(a_wa.size()), 32'd0);
        check("abort_idle_done", 32'(a_done), 32'd1);

        // Fresh run after the abort.
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        cyc = 0;
        while (a_done !== 1'b1 && cyc < 1000) begin @(negedge clk); cyc++; end
        check("rerun_latency", 32'(cyc), 32'd76);
        check("rerun_nwrites", 32'(a_wa.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rerun_addr%0d", i), 32'(a_wa[i]), 32'h0300 + 32'(i));
            check($sformatf("rerun_data%0d", i), a_wd[i], dig[255 - 32*i -: 32]);
        end

        // 16 nonces over 4 lanes; nonces 1 and 3 share the smallest h0.
        cand = rand256(); best = sha_ref(cand);
        for (int i = 0; i < 40; i++) begin
            msg = rand256(); dig = sha_ref(msg);
            if (dig[255:224] < best[255:224]) begin cand = msg; best = dig; end
        end
        for (int n = 0; n < 16; n++) begin
            if (n == 1 || n == 3) begin
                msg = cand; dig = best;
            end else begin
                do begin msg = rand256(); dig = sha_ref(msg); end while (dig[255:224] <= best[255:224]);
            end
            b_hin[n*256 +: 256] = msg;
            b_exp[n] = dig;
        end
        b_addr = 16'h2000; b_wa.delete(); b_wd.delete();
        b_start = 1'b1; @(negedge clk); b_start = 1'b0;
        cyc = 0;
        while (b_done !== 1'b1 && cyc < 2000) begin @(negedge clk); cyc++; end
        check("multi_latency", 32'(cyc), 32'd394);
        check("multi_nwrites", 32'(b_wa.size()), 32'd128);
        for (int k = 0; k < 128; k++) begin
            dig = b_exp[k / 8];
            check($sformatf("multi_addr%0d", k), 32'(b_wa[k]), 32'h2000 + 32'(k));
            check($sformatf("multi_data%0d", k), b_wd[k], dig[255 - 32*(k % 8) -: 32]);
        end
`ifdef SHA256_NONCE_MIN_TRACK_EN
        check("min_nonce", 32'(b_min_nonce), 32'd1);
        check("min_h0", b_min_h0, best[255:224]);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
